// File: rtl/gas_alarm_controller_pkg.sv
// Shared definitions for the gas alarm controller.
//   LEVEL_W : width of the sensor level bus
//   state_t : alarm FSM state encoding (SAFE=0, WARN=1, ALARM=2, ACKED=3)
package gas_alarm_controller_pkg;

  localparam int unsigned LEVEL_W = 3;

  typedef enum logic [1:0] {
    ST_SAFE  = 2'd0,
    ST_WARN  = 2'd1,
    ST_ALARM = 2'd2,
    ST_ACKED = 2'd3
  } state_t;

endpackage

// File: rtl/gas_alarm_controller_persist_counter.sv
// Persistence counter: counts consecutive qualifying samples, saturating at
// TARGET. It clears on any non-qualifying sample or on clr.
//   clk       : system clock, rising edge
//   arst      : synchronous active-high reset
//   clr       : synchronous clear (state transition)
//   qual      : current sample qualifies
//   done_next : current sample is the TARGET-th consecutive qualifying one
module persist_counter #(
  parameter int unsigned TARGET = 3,
  parameter int unsigned W      = 4
) (
  input  logic clk,
  input  logic arst,
  input  logic clr,
  input  logic qual,
  output logic done_next
);

  localparam logic [W-1:0] LP_TGT  = W'(TARGET);
  localparam logic [W-1:0] LP_LAST = W'(TARGET - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (arst || clr || !qual) begin
      r_cnt <= '0;
    end else if (r_cnt != LP_TGT) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign done_next = qual && (r_cnt == LP_LAST);

endmodule

// File: rtl/gas_alarm_controller.sv
// Gas alarm controller: filters the sensor level with persistence counters,
// runs the SAFE/WARN/ALARM/ACKED FSM, drives warn/alarm/buzzer and keeps the
// peak level and alarm event count for the panel.
//   clk       : system clock, rising edge
//   arst      : synchronous active-high reset
//   level     : gas level from sensor
//   ack       : operator acknowledge (only honoured in ALARM)
//   state     : FSM state
//   warn      : 1 in WARN
//   alarm     : 1 in ALARM or ACKED
//   buzzer    : square wave while in ALARM
//   peak      : max level seen since leaving SAFE
//   event_cnt : ALARM entries, saturating at 255
module gas_alarm_controller
  import gas_alarm_controller_pkg::*;
#(
  parameter logic [LEVEL_W-1:0] WARN_TH  = 3'd2,
  parameter logic [LEVEL_W-1:0] ALARM_TH = 3'd5,
  parameter logic [LEVEL_W-1:0] CLEAR_TH = 3'd1,
  parameter int unsigned        PERSIST  = 3,
  parameter int unsigned        HOLD     = 4,
  parameter int unsigned        BEEP_DIV = 2
) (
  input  logic               clk,
  input  logic               arst,
  input  logic [LEVEL_W-1:0] level,
  input  logic               ack,
  output logic [1:0]         state,
  output logic               warn,
  output logic               alarm,
  output logic               buzzer,
  output logic [LEVEL_W-1:0] peak,
  output logic [7:0]         event_cnt
);

  localparam logic [3:0] LP_BEEP_LAST = 4'(BEEP_DIV - 1);

  state_t             r_state;
  state_t             w_next;
  logic               w_trans;
  logic               w_hi_done;
  logic               w_wr_done;
  logic               w_lo_done;
  logic               w_rise_done;
  logic [LEVEL_W-1:0] r_peak;
  logic [LEVEL_W-1:0] r_ack_peak;
  logic [3:0]         r_beep;
  logic               r_buzzer;
  logic [7:0]         r_event;

  assign w_trans = (w_next != r_state);

  persist_counter #(.TARGET(PERSIST), .W(4)) u_hi (
    .clk(clk), .arst(arst), .clr(w_trans),
    .qual(level >= ALARM_TH), .done_next(w_hi_done)
  );

  persist_counter #(.TARGET(PERSIST), .W(4)) u_wr (
    .clk(clk), .arst(arst), .clr(w_trans),
    .qual(level >= WARN_TH), .done_next(w_wr_done)
  );

  persist_counter #(.TARGET(HOLD), .W(4)) u_lo (
    .clk(clk), .arst(arst), .clr(w_trans),
    .qual(level < CLEAR_TH), .done_next(w_lo_done)
  );

  persist_counter #(.TARGET(PERSIST), .W(4)) u_rise (
    .clk(clk), .arst(arst), .clr(w_trans),
    .qual(level > r_ack_peak), .done_next(w_rise_done)
  );

  always_ff @(posedge clk) begin
    if (arst) r_state <= ST_SAFE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_SAFE: begin
        if (w_hi_done)      w_next = ST_ALARM;
        else if (w_wr_done) w_next = ST_WARN;
      end
      ST_WARN: begin
        if (w_hi_done)      w_next = ST_ALARM;
        else if (w_lo_done) w_next = ST_SAFE;
      end
      ST_ALARM: begin
        if (ack) w_next = ST_ACKED;
      end
      ST_ACKED: begin
        if (w_lo_done)        w_next = ST_SAFE;
        else if (w_rise_done) w_next = ST_ALARM;
      end
      default: w_next = ST_SAFE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      r_peak     <= '0;
      r_ack_peak <= '0;
      r_beep     <= '0;
      r_buzzer   <= 1'b0;
      r_event    <= '0;
    end else begin
      // Staying in SAFE also lands here, which keeps peak at 0 there.
      if (w_next == ST_SAFE)  r_peak <= '0;
      else if (level > r_peak) r_peak <= level;

      if (r_state == ST_ALARM && ack) r_ack_peak <= r_peak;

      if (w_next == ST_ALARM) begin
        if (r_state != ST_ALARM) begin
          r_beep   <= '0;
          r_buzzer <= 1'b1;
          if (r_event != 8'hFF) r_event <= r_event + 8'd1;
        end else if (r_beep == LP_BEEP_LAST) begin
          r_beep   <= '0;
          r_buzzer <= ~r_buzzer;
        end else begin
          r_beep <= r_beep + 4'd1;
        end
      end else begin
        r_beep   <= '0;
        r_buzzer <= 1'b0;
      end
    end
  end

  assign state     = r_state;
  assign warn      = (r_state == ST_WARN);
  assign alarm     = (r_state == ST_ALARM) || (r_state == ST_ACKED);
  assign buzzer    = r_buzzer;
  assign peak      = r_peak;
  assign event_cnt = r_event;

endmodule

// File: tb/tb_gas_alarm_controller.sv
module tb_gas_alarm_controller;

  localparam int P   = 3;
  localparam int H   = 4;
  localparam int BD  = 2;
  localparam int WTH = 2;
  localparam int ATH = 5;
  localparam int CTH = 1;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic [2:0] level = 3'd0;
  logic       ack = 1'b0;
  logic [1:0] state;
  logic       warn, alarm, buzzer;
  logic [2:0] peak;
  logic [7:0] event_cnt;

  gas_alarm_controller #(
    .WARN_TH(3'd2), .ALARM_TH(3'd5), .CLEAR_TH(3'd1),
    .PERSIST(P), .HOLD(H), .BEEP_DIV(BD)
  ) dut (
    .clk(clk), .arst(arst), .level(level), .ack(ack),
    .state(state), .warn(warn), .alarm(alarm), .buzzer(buzzer),
    .peak(peak), .event_cnt(event_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st; int wr; int al; int bz; int pk; int ev;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: samples since the last state change, plus scalars.
  int   hist[$];
  int   m_st = 0, m_pk = 0, m_ackpk = 0, m_ev = 0, m_k = 0, m_bz = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // kind 0: all >= th, kind 1: all < th, kind 2: all > th, over last n samples
  function automatic bit last_n(input int n, input int kind, input int th);
    if (hist.size() < n) return 1'b0;
    for (int i = hist.size() - n; i < hist.size(); i++) begin
      case (kind)
        0: if (!(hist[i] >= th)) return 1'b0;
        1: if (!(hist[i] <  th)) return 1'b0;
        default: if (!(hist[i] > th)) return 1'b0;
      endcase
    end
    return 1'b1;
  endfunction

  task automatic model(input int lv, input bit a, input bit r);
    exp_t e;
    int   nx;
    if (r) begin
      m_st = 0; m_pk = 0; m_ackpk = 0; m_ev = 0; m_k = 0; m_bz = 0;
      hist.delete();
    end else begin
      hist.push_back(lv);
      nx = m_st;
      case (m_st)
        0: if (last_n(P, 0, ATH)) nx = 2; else if (last_n(P, 0, WTH)) nx = 1;
        1: if (last_n(P, 0, ATH)) nx = 2; else if (last_n(H, 1, CTH)) nx = 0;
        2: if (a) begin nx = 3; m_ackpk = m_pk; end
        default: if (last_n(H, 1, CTH)) nx = 0; else if (last_n(P, 2, m_ackpk)) nx = 2;
      endcase
      m_pk = (nx == 0) ? 0 : ((lv > m_pk) ? lv : m_pk);
      if (nx == 2) begin
        if (m_st != 2) begin
          m_k = 0;
          if (m_ev < 255) m_ev++;
        end else m_k++;
        m_bz = (((m_k / BD) % 2) == 0) ? 1 : 0;
      end else m_bz = 0;
      if (nx != m_st) hist.delete();
      m_st = nx;
    end
    e.st = m_st; e.wr = (m_st == 1); e.al = (m_st >= 2);
    e.bz = m_bz; e.pk = m_pk; e.ev = m_ev;
    sbq.push_back(e);
  endtask

  task automatic step(input int lv, input bit a, input bit r);
    @(negedge clk);
    #1;
    level = 3'(lv); ack = a; arst = r;
    model(lv, a, r);
  endtask

  task automatic steps(input int lv, input int n);
    for (int i = 0; i < n; i++) step(lv, 1'b0, 1'b0);
  endtask

  // Monitor: every edge produces a full output set; compare at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("state",     int'(state),     e.st);
      chk("warn",      int'(warn),      e.wr);
      chk("alarm",     int'(alarm),     e.al);
      chk("buzzer",    int'(buzzer),    e.bz);
      chk("peak",      int'(peak),      e.pk);
      chk("event_cnt", int'(event_cnt), e.ev);
    end
  end

  initial begin
    int lv, len;
    bit a, r;

    // reset held with a high level, then release
    step(7, 0, 1); step(7, 0, 1);
    steps(7, 4);
    step(7, 1, 0);
    steps(0, 4);
    // warn then clear
    steps(3, 3);
    steps(0, 4);
    // straight to alarm, buzzer pattern
    steps(6, 7);
    // ack, re-alarm, ack, clear
    step(6, 1, 0);
    steps(7, 3);
    step(7, 1, 0);
    steps(0, 4);
    // glitch rejection
    step(6, 0, 0); step(6, 0, 0); step(0, 0, 0);
    steps(0, 2);
    step(3, 0, 0); step(3, 0, 0); step(6, 0, 0);
    steps(6, 2);
    steps(0, 5);
    // reset mid-alarm
    steps(6, 5);
    step(6, 0, 1);
    steps(0, 2);
    // ack outside ALARM ignored, lower ack peak allows re-alarm on rise
    step(0, 1, 0);
    steps(5, 4);
    step(5, 1, 0);
    steps(6, 3);
    steps(3, 3);
    steps(0, 4);

    // randomized segments
    for (int s = 0; s < 250; s++) begin
      lv  = $urandom_range(0, 7);
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        a = ($urandom_range(0, 5) == 0);
        r = ($urandom_range(0, 149) == 0);
        step(lv, a, r);
      end
    end

    // event counter saturation
    step(0, 0, 1);
    for (int n = 0; n < 257; n++) begin
      steps(7, 3);
      step(7, 1, 0);
      steps(0, 4);
    end
    @(negedge clk);
    chk("event_cnt_saturated", int'(event_cnt), 255);

    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain pending=%0d expected=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
